ex_mem_pipe_reg: RTL and testbench

Parametrised EX/MEM pipeline stage register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating back-pressure counter. It replaces the free-running EX/MEM register. The MEM stage can now stall EX without losing a beat, and branch/exception logic can squash in-flight instructions. It sits between the ALU/matrix-issue EX stage and the data-memory / matrix-load MEM stage.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_skid_reg.sv | 71 +++++++
 rtl/ex_mem_pipe_reg.sv | 124 ++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline types and default core widths.
// Default payload layout plus the bubble helper for the default core.
package pipe_pkg;

   localparam int DEF_XLEN       = 32;
   localparam int DEF_REG_AW     = 5;
   localparam int DEF_SEL_W      = 2;
   localparam int DEF_NUM_MAT_CH = 2;
   localparam int DEF_CNT_W      = 16;

   typedef struct packed {
      logic [DEF_REG_AW-1:0]     rs1;
      logic [DEF_REG_AW-1:0]     rs2;
      logic [DEF_REG_AW-1:0]     rd;
      logic [DEF_XLEN-1:0]       alu_result;
      logic [DEF_XLEN-1:0]       store_data;
      logic                      reg_write;
      logic                      mem_write;
      logic                      mem_read;
      logic [DEF_SEL_W-1:0]      out_sel;
      logic [DEF_NUM_MAT_CH-1:0] mat_en;
   } ex_mem_payload_t;

   // Turn a beat into a bubble: side-effecting controls off, data kept.
   function automatic ex_mem_payload_t payload_bubble(
      input ex_mem_payload_t p
   );
      ex_mem_payload_t b;
      b           = p;
      b.reg_write = 1'b0;
      b.mem_write = 1'b0;
      b.mem_read  = 1'b0;
      b.mat_en    = '0;
      return b;
   endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic W-bit two-entry skid register with valid/ready and flush.
// in_ready depends only on registered state (no out_ready path).
module pipe_skid_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         main_vld_q, main_vld_d;
   logic         skid_vld_q, skid_vld_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         accept;

   assign in_ready_o  = ~skid_vld_q;
   assign accept      = in_valid_i & in_ready_o;
   assign out_valid_o = main_vld_q;
   assign out_data_o  = main_q;

   // Next-state: EMPTY / ONE / TWO occupancy with flush taking priority.
   always_comb begin
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_d     = main_q;
      skid_d     = skid_q;
      if (flush_i) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q) begin
         if (accept) begin
            main_d     = in_data_i;
            main_vld_d = 1'b1;
         end
      end else if (!skid_vld_q) begin
         if (out_ready_i) begin
            if (accept) main_d = in_data_i;
            else        main_vld_d = 1'b0;
         end else if (accept) begin
            skid_d     = in_data_i;
            skid_vld_d = 1'b1;
         end
      end else if (out_ready_i) begin
         main_d     = skid_q;
         skid_vld_d = 1'b0;
      end
   end

   // Occupancy and data registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM stage register: skid-buffered handshake, flush,
// bubble masking of controls and a saturating stall counter.
module ex_mem_pipe_reg
   import pipe_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int REG_AW     = DEF_REG_AW,
   parameter int SEL_W      = DEF_SEL_W,
   parameter int NUM_MAT_CH = DEF_NUM_MAT_CH,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_AW-1:0]     in_rs1,
   input  logic [REG_AW-1:0]     in_rs2,
   input  logic [REG_AW-1:0]     in_rd,
   input  logic [XLEN-1:0]       in_alu_result,
   input  logic [XLEN-1:0]       in_store_data,
   input  logic                  in_reg_write,
   input  logic                  in_mem_write,
   input  logic                  in_mem_read,
   input  logic [SEL_W-1:0]      in_out_sel,
   input  logic [NUM_MAT_CH-1:0] in_mat_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [REG_AW-1:0]     out_rs1,
   output logic [REG_AW-1:0]     out_rs2,
   output logic [REG_AW-1:0]     out_rd,
   output logic [XLEN-1:0]       out_alu_result,
   output logic [XLEN-1:0]       out_store_data,
   output logic                  out_reg_write,
   output logic                  out_mem_write,
   output logic                  out_mem_read,
   output logic [SEL_W-1:0]      out_out_sel,
   output logic [NUM_MAT_CH-1:0] out_mat_en,
   input  logic                  stall_cnt_clr,
   output logic [CNT_W-1:0]      stall_cnt
);

   typedef struct packed {
      logic [REG_AW-1:0]     rs1;
      logic [REG_AW-1:0]     rs2;
      logic [REG_AW-1:0]     rd;
      logic [XLEN-1:0]       alu_result;
      logic [XLEN-1:0]       store_data;
      logic                  reg_write;
      logic                  mem_write;
      logic                  mem_read;
      logic [SEL_W-1:0]      out_sel;
      logic [NUM_MAT_CH-1:0] mat_en;
   } pay_t;

   localparam int PW = $bits(pay_t);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   pay_t             in_pay;
   pay_t             out_pay;
   logic [PW-1:0]    out_bits;
   logic             stall;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign in_pay = '{
      rs1:        in_rs1,
      rs2:        in_rs2,
      rd:         in_rd,
      alu_result: in_alu_result,
      store_data: in_store_data,
      reg_write:  in_reg_write,
      mem_write:  in_mem_write,
      mem_read:   in_mem_read,
      out_sel:    in_out_sel,
      mat_en:     in_mat_en
   };

   pipe_skid_reg #(
      .W (PW)
   ) u_skid (
      .clk         (clk),
      .rst_i       (reset),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_pay),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_bits)
   );

   assign out_pay = pay_t'(out_bits);

   assign out_rs1        = out_pay.rs1;
   assign out_rs2        = out_pay.rs2;
   assign out_rd         = out_pay.rd;
   assign out_alu_result = out_pay.alu_result;
   assign out_store_data = out_pay.store_data;
   assign out_out_sel    = out_pay.out_sel;
   assign out_reg_write  = out_pay.reg_write & out_valid;
   assign out_mem_write  = out_pay.mem_write & out_valid;
   assign out_mem_read   = out_pay.mem_read & out_valid;
   assign out_mat_en     = out_pay.mat_en & {NUM_MAT_CH{out_valid}};

   assign stall     = out_valid & ~out_ready;
   assign stall_cnt = cnt_q;

   // Stall counter next-state: clear wins, then saturating increment.
   always_comb begin
      cnt_d = cnt_q;
      if (stall_cnt_clr) begin
         cnt_d = '0;
      end else if (stall && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Stall counter register; flush deliberately leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: FIFO scoreboard plus directed
// checks of reset, back-pressure, flush, bubbles, counter.
module tb_ex_mem_pipe_reg;

   localparam int XLEN  = 32;
   localparam int RAW   = 5;
   localparam int SELW  = 2;
   localparam int NCH   = 2;
   localparam int CNTW  = 4;
   localparam int PW    = 3*RAW + 2*XLEN + 3 + SELW + NCH;

   logic            clk = 1'b0;
   logic            reset, flush, in_valid, in_ready;
   logic [RAW-1:0]  in_rs1, in_rs2, in_rd;
   logic [XLEN-1:0] in_alu_result, in_store_data;
   logic            in_reg_write, in_mem_write, in_mem_read;
   logic [SELW-1:0] in_out_sel;
   logic [NCH-1:0]  in_mat_en;
   logic            out_valid, out_ready;
   logic [RAW-1:0]  out_rs1, out_rs2, out_rd;
   logic [XLEN-1:0] out_alu_result, out_store_data;
   logic            out_reg_write, out_mem_write, out_mem_read;
   logic [SELW-1:0] out_out_sel;
   logic [NCH-1:0]  out_mat_en;
   logic            stall_cnt_clr;
   logic [CNTW-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;
   int nxfer    = 0;
   logic [PW-1:0] sb_q[$];

   always #5 clk = ~clk;

   ex_mem_pipe_reg #(
      .XLEN(XLEN), .REG_AW(RAW), .SEL_W(SELW),
      .NUM_MAT_CH(NCH), .CNT_W(CNTW)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_alu_result(in_alu_result), .in_store_data(in_store_data),
      .in_reg_write(in_reg_write), .in_mem_write(in_mem_write),
      .in_mem_read(in_mem_read), .in_out_sel(in_out_sel),
      .in_mat_en(in_mat_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_alu_result(out_alu_result), .out_store_data(out_store_data),
      .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
      .out_mem_read(out_mem_read), .out_out_sel(out_out_sel),
      .out_mat_en(out_mat_en),
      .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt)
   );

   wire [PW-1:0] in_pack = {in_rs1, in_rs2, in_rd, in_alu_result,
      in_store_data, in_reg_write, in_mem_write, in_mem_read,
      in_out_sel, in_mat_en};
   wire [PW-1:0] out_pack = {out_rs1, out_rs2, out_rd, out_alu_result,
      out_store_data, out_reg_write, out_mem_write, out_mem_read,
      out_out_sel, out_mat_en};

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [XLEN-1:0] alu, input logic rw,
                        input logic mw, input logic [NCH-1:0] me);
      in_valid      = 1'b1;
      in_rs1        = RAW'($urandom);
      in_rs2        = RAW'($urandom);
      in_rd         = RAW'($urandom);
      in_alu_result = alu;
      in_store_data = $urandom;
      in_reg_write  = rw;
      in_mem_write  = mw;
      in_mem_read   = 1'($urandom);
      in_out_sel    = SELW'($urandom);
      in_mat_en     = me;
   endtask

   // Scoreboard: compare on transfer, push on accept, drop on flush.
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            nxfer++;
            if (sb_q.size() == 0) chk("sb_under", 128'(sb_q.size()), 1);
            else chk("sb_data", out_pack, sb_q.pop_front());
         end
         if (flush) sb_q.delete();
         else if (in_valid && in_ready) sb_q.push_back(in_pack);
      end
   end

   initial begin
      logic acc;
      int   base;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; stall_cnt_clr = 1'b0;
      drive(0, 0, 0, 0);
      in_valid = 1'b0;
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_cnt", stall_cnt, 0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // streaming, 1-cycle latency, no bubbles
      out_ready = 1'b1;
      base = nxfer;
      for (int i = 0; i < 8; i++) begin
         drive(32'h100 + i, 1'($urandom), 1'($urandom), NCH'($urandom));
         tick();
         if (i == 0) chk("lat_valid", out_valid, 1);
         if (i == 0) chk("lat_data", out_alu_result, 32'h100);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_cnt", nxfer - base, 8);
      chk("stream_idle", out_valid, 0);

      // back-pressure: A held, B in skid, C held off
      out_ready = 1'b0;
      stall_cnt_clr = 1'b1;
      tick();
      stall_cnt_clr = 1'b0;
      drive(32'hA, 1, 0, 0);
      tick();
      drive(32'hB, 0, 1, 1);
      tick();
      chk("bp_ready", in_ready, 0);
      drive(32'hC, 1, 1, 2);
      tick(); tick(); tick();
      chk("bp_hold", out_alu_result, 32'hA);
      chk("bp_cnt", stall_cnt, 4);
      out_ready = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) begin
         acc = in_ready;
         tick();
      end
      chk("bp_c_acc", acc, 1);
      in_valid = 1'b0;
      tick(); tick();
      chk("bp_drain", out_valid, 0);
      chk("bp_cnt_keep", stall_cnt, 4);

      // flush in TWO with a same-cycle offer
      out_ready = 1'b0;
      stall_cnt_clr = 1'b1;
      drive(32'h1, 1, 1, 3);
      tick();
      stall_cnt_clr = 1'b0;
      drive(32'h2, 1, 1, 3);
      tick();
      chk("fl_two", in_ready, 0);
      flush = 1'b1;
      drive(32'h3, 1, 1, 3);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_ctrl", {out_reg_write, out_mem_write,
                      out_mem_read, out_mat_en}, 0);
      chk("fl_ready", in_ready, 1);
      chk("fl_cnt", stall_cnt, 2);
      out_ready = 1'b1;
      tick(); tick();
      chk("fl_gone", out_valid, 0);

      // bubble masking keeps data
      drive(32'hBEEF, 1, 1, 3);
      tick();
      in_valid = 1'b0;
      chk("bub_live", {out_reg_write, out_mem_write, out_mat_en}, 4'hF);
      tick();
      chk("bub_ctrl", {out_reg_write, out_mem_write,
                       out_mem_read, out_mat_en}, 0);
      chk("bub_data", out_alu_result, 32'hBEEF);

      // counter saturation and clear
      out_ready = 1'b0;
      stall_cnt_clr = 1'b1;
      drive(32'h55, 0, 0, 0);
      tick();
      stall_cnt_clr = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_15", stall_cnt, 15);
      tick(); tick();
      chk("sat_hold", stall_cnt, 15);
      stall_cnt_clr = 1'b1;
      tick();
      stall_cnt_clr = 1'b0;
      chk("sat_clr", stall_cnt, 0);
      tick();
      chk("sat_resume", stall_cnt, 1);

      // reset mid-cycle with beats held
      drive(32'h77, 1, 1, 3);
      tick();
      in_valid = 1'b0;
      chk("mr_two", in_ready, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("mr_valid", out_valid, 0);
      chk("mr_out", out_pack, 0);
      chk("mr_cnt", stall_cnt, 0);
      chk("mr_ready", in_ready, 1);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      chk("mr_after", in_ready, 1);
      chk("mr_empty", out_valid, 0);
      chk("sb_left", 128'(sb_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
